ioctl_upload_reader: RTL and testbench
======================================

Name: ioctl_upload_reader

Overview:
- Reader end of the HPS ioctl byte-stream protocol: services ioctl upload requests by reading bytes from a game-side RAM and presenting them on ioctl_din.
- Used to save NVRAM and high-score tables to the HPS. It mirrors the download path that fills ROMs and DIP switches.
- Sits between hps_io and a dual-port RAM port in the clk_sys domain.
- Arbitrates access with the game by requesting a CPU pause before reading.

Parameters:
- UPLOAD_INDEX, 8'd4: ioctl_index value this block responds to.
- RAM_AW, 11: RAM address width in bits.
- RAM_BYTES, 2048: valid bytes. Addresses at or above this return PAD_BYTE.
- RD_LAT, 1: RAM read latency in cycles, from ram_addr to ram_dout. Legal range 1..3.
- PAD_BYTE, 8'hFF: byte returned for out-of-range addresses.

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- save_trig  in  1  level from OSD status. A rising edge requests a save.
- ioctl_upload_req  out  1  one-cycle pulse asking the HPS to start an upload.
- ioctl_upload  in  1  high while the HPS upload session is active.
- ioctl_index  in  8  stream index.
- ioctl_rd  in  1  one-cycle byte read strobe.
- ioctl_addr  in  25  byte address, valid while ioctl_rd is high.
- ioctl_din  out  8  byte returned to the HPS.
- pause_req  out  1  asks the game CPU to halt RAM access.
- pause_ack  in  1  game has released the RAM.
- ram_addr  out  RAM_AW  RAM read address.
- ram_rd  out  1  RAM read enable.
- ram_dout  in  8  RAM read data.
- busy  out  1  a session is in progress.

Behaviour:
- Reset values:
  - All outputs 0, except ioctl_din = 8'h00.
  - State is IDLE.
  - save_trig edge register = 0.
- Active session: ioctl_upload is high and ioctl_index equals UPLOAD_INDEX. ioctl_rd pulses for any other index are ignored.
- save_trig rising edge in IDLE with no active session:
  - Pulse ioctl_upload_req high for exactly 1 cycle.
  - Ignore further edges until the session ends and the state returns to IDLE.
- States and transitions:
  - IDLE -> PAUSE when a session becomes active. Set pause_req = 1 and busy = 1.
  - PAUSE -> READY when pause_ack = 1.
    - An ioctl_rd arriving in PAUSE is latched in a single pending flag with its address, and is served on entry to READY.
    - A second ioctl_rd while the flag is still pending overwrites the latched address. This is a protocol violation; no error is flagged.
  - READY -> FETCH on ioctl_rd (or on the pending flag).
    - Address within range (ioctl_addr < RAM_BYTES): drive ram_addr = ioctl_addr[RAM_AW-1:0] and ram_rd = 1 for 1 cycle; the upper bits must be 0.
    - Address out of range: no RAM access; load ioctl_din = PAD_BYTE on the next cycle and return to READY.
  - FETCH: count RD_LAT cycles, capture ram_dout into ioctl_din, then return to READY.
    - ioctl_din changes only at that capture and holds until the next read.
    - Latency from ioctl_rd to ioctl_din valid is RD_LAT+1 cycles, with no pause stall.
    - hps_io spaces read strobes at least 8 cycles apart.
    - An ioctl_rd arriving during FETCH is latched as pending and served immediately after.
  - Any state -> IDLE when the session ends (ioctl_upload falls):
    - pause_req and busy drop the next cycle.
    - An in-flight RAM read is abandoned.
    - ioctl_din keeps its last value.
- Reset mid-session: immediate return to IDLE, with pause_req = 0 on the next cycle.
- Address arithmetic: full 25-bit compare against RAM_BYTES; ram_addr is a truncation after the compare passes.

Decomposition:
- Shared package ioctl_pkg:
  - ioctl index constants (ROM = 0, DIP = 254, NVRAM = 4).
  - state enum typedef.
  - IOCTL_AW = 25.
- One sub-module: rising_edge_pulse, for the save_trig edge detector. It is reusable for other OSD triggers.

Test Plan:
1. Trigger request: save_trig rises, no active session -> ioctl_upload_req high for exactly 1 cycle. A second edge 5 cycles later gives no pulse.
2. Basic reads (RD_LAT = 1):
   - Stimulus: session active with index 4; pause_ack arrives 3 cycles after pause_req; RAM preloaded addr N = N^8'h5A; read addr 0, 1, 0x7FF, strobes 8 cycles apart.
   - Response: ioctl_din = 5A, 5B, A5 respectively, each valid 2 cycles after its strobe.
3. Out of range: ioctl_rd with addr 0x800 and 0x1000000 -> ioctl_din = FF, with no ram_rd pulse.
4. Stall: ioctl_rd at addr 0x10 while pause_ack is low for 20 cycles -> exactly one ram_rd, on the cycle after pause_ack rises. ioctl_din = 0x4A, 2 cycles later.
5. Wrong index: index 0 with ioctl_upload = 1 and ioctl_rd pulses -> pause_req stays 0, no ram_rd, ioctl_din unchanged.
6. Session abort and reset:
   - ioctl_upload falls during FETCH (RD_LAT = 3) -> pause_req = 0 and busy = 0 next cycle; ioctl_din retains its prior byte.
   - Repeat with reset instead -> all outputs return to reset values.

Source files
------------

// File: rtl/ioctl_pkg.sv
// Shared ioctl definitions: stream index constants, address width and the
// upload reader state encoding.
package ioctl_pkg;

  localparam int unsigned IOCTL_AW = 25;

  localparam logic [7:0] IDX_ROM   = 8'd0;
  localparam logic [7:0] IDX_DIP   = 8'd254;
  localparam logic [7:0] IDX_NVRAM = 8'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAUSE = 2'd1,
    READY = 2'd2,
    FETCH = 2'd3
  } state_t;

endpackage

// File: rtl/rising_edge_pulse.sv
// Rising-edge detector for slow OSD level triggers.
// Ports: clk, reset (sync, active-high), level (input level),
//        pulse_c (combinational, high for the cycle where level first reads 1).
module rising_edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse_c
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign pulse_c = level & ~level_q;

endmodule

// File: rtl/ioctl_upload_reader.sv
// Reader end of the HPS ioctl upload stream: requests a game CPU pause, then
// answers each ioctl_rd with a byte read from game RAM (or PAD_BYTE when the
// address is beyond RAM_BYTES).
// Ports: clk_sys/reset; save_trig -> ioctl_upload_req (save request pulse);
//        ioctl_upload/index/rd/addr from hps_io, ioctl_din back to it;
//        pause_req/pause_ack handshake with the game; ram_addr/ram_rd/ram_dout
//        to the RAM read port; busy while a session is open.
module ioctl_upload_reader
  import ioctl_pkg::*;
#(
  parameter logic [7:0]  UPLOAD_INDEX = IDX_NVRAM,
  parameter int unsigned RAM_AW       = 11,
  parameter int unsigned RAM_BYTES    = 2048,
  parameter int unsigned RD_LAT       = 1,
  parameter logic [7:0]  PAD_BYTE     = 8'hFF
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                save_trig,
  output logic                ioctl_upload_req,
  input  logic                ioctl_upload,
  input  logic [7:0]          ioctl_index,
  input  logic                ioctl_rd,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  output logic [7:0]          ioctl_din,
  output logic                pause_req,
  input  logic                pause_ack,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic                ram_rd,
  input  logic [7:0]          ram_dout,
  output logic                busy
);

  localparam int unsigned CNT_W = 2;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                pend, pend_n;
  logic [IOCTL_AW-1:0] pend_addr, pend_addr_n;
  logic                req_sent, req_sent_n;
  logic [RAM_AW-1:0]   ram_addr_n;
  logic                ram_rd_n, pause_req_n, busy_n, upload_req_n;
  logic [7:0]          din_n;

  logic                trig_c, active_c, rd_hit_c, serve_c, in_range_c;
  logic [IOCTL_AW-1:0] serve_addr_c;

  rising_edge_pulse u_save_edge (
    .clk     (clk_sys),
    .reset   (reset),
    .level   (save_trig),
    .pulse_c (trig_c)
  );

  assign active_c   = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign rd_hit_c   = ioctl_rd && active_c;
  assign in_range_c = serve_addr_c < IOCTL_AW'(RAM_BYTES);

  // State and registered outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      pend             <= 1'b0;
      pend_addr        <= '0;
      req_sent         <= 1'b0;
      ram_addr         <= '0;
      ram_rd           <= 1'b0;
      ioctl_din        <= 8'h00;
      pause_req        <= 1'b0;
      busy             <= 1'b0;
      ioctl_upload_req <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      pend             <= pend_n;
      pend_addr        <= pend_addr_n;
      req_sent         <= req_sent_n;
      ram_addr         <= ram_addr_n;
      ram_rd           <= ram_rd_n;
      ioctl_din        <= din_n;
      pause_req        <= pause_req_n;
      busy             <= busy_n;
      ioctl_upload_req <= upload_req_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pend_n       = pend;
    pend_addr_n  = pend_addr;
    req_sent_n   = req_sent;
    ram_addr_n   = ram_addr;
    ram_rd_n     = 1'b0;
    din_n        = ioctl_din;
    pause_req_n  = pause_req;
    busy_n       = busy;
    upload_req_n = 1'b0;
    serve_c      = 1'b0;
    serve_addr_c = ioctl_addr;

    case (state)
      IDLE: begin
        if (active_c) begin
          state_n     = PAUSE;
          pause_req_n = 1'b1;
          busy_n      = 1'b1;
          req_sent_n  = 1'b0;
          pend_n      = 1'b0;
        end else if (trig_c && !req_sent) begin
          // One request per save; re-armed once a session has run
          upload_req_n = 1'b1;
          req_sent_n   = 1'b1;
        end
      end
      PAUSE: begin
        if (pause_ack) begin
          // RAM is ours now: serve a read held during the pause right away
          state_n      = READY;
          serve_c      = rd_hit_c || pend;
          serve_addr_c = rd_hit_c ? ioctl_addr : pend_addr;
          pend_n       = 1'b0;
        end else if (rd_hit_c) begin
          pend_n      = 1'b1;
          pend_addr_n = ioctl_addr;
        end
      end
      READY: begin
        serve_c      = rd_hit_c || pend;
        serve_addr_c = rd_hit_c ? ioctl_addr : pend_addr;
        pend_n       = 1'b0;
      end
      FETCH: begin
        if (rd_hit_c) begin
          pend_n      = 1'b1;
          pend_addr_n = ioctl_addr;
        end
        if (cnt == CNT_W'(RD_LAT)) begin
          din_n   = ram_dout;
          state_n = READY;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Start a RAM read, or answer out-of-range addresses with padding
    if (serve_c) begin
      if (in_range_c) begin
        state_n    = FETCH;
        cnt_n      = '0;
        ram_addr_n = serve_addr_c[RAM_AW-1:0];
        ram_rd_n   = 1'b1;
      end else begin
        din_n   = PAD_BYTE;
        state_n = READY;
      end
    end

    // Session end abandons whatever was in flight; ioctl_din keeps its byte
    if (state != IDLE && !active_c) begin
      state_n     = IDLE;
      pause_req_n = 1'b0;
      busy_n      = 1'b0;
      ram_rd_n    = 1'b0;
      pend_n      = 1'b0;
      din_n       = ioctl_din;
    end
  end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader: two instances (RD_LAT 1 and 3) share the
// stimulus; each has its own RAM model holding addr ^ 8'h5A.
module tb_ioctl_upload_reader;
  import ioctl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, save_trig, ioctl_upload, ioctl_rd, pause_ack;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;

  logic        req1, pause1, busy1, ram_rd1, req3, pause3, busy3, ram_rd3;
  logic [7:0]  din1, din3, ram_dout1, ram_dout3, r3a, r3b;
  logic [10:0] ram_addr1, ram_addr3, last_ra1, last_ra3;
  logic [7:0]  mem [2048];

  int tests = 0, errors = 0;
  int nrd1 = 0, nrd3 = 0, nreq1 = 0, nreq3 = 0;
  logic [7:0] exp_din;

  always #5 clk = ~clk;

  ioctl_upload_reader #(.RD_LAT(1)) u_dut1 (
    .clk_sys(clk), .reset(reset), .save_trig(save_trig), .ioctl_upload_req(req1),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(din1), .pause_req(pause1), .pause_ack(pause_ack),
    .ram_addr(ram_addr1), .ram_rd(ram_rd1), .ram_dout(ram_dout1), .busy(busy1));

  ioctl_upload_reader #(.RD_LAT(3)) u_dut3 (
    .clk_sys(clk), .reset(reset), .save_trig(save_trig), .ioctl_upload_req(req3),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(din3), .pause_req(pause3), .pause_ack(pause_ack),
    .ram_addr(ram_addr3), .ram_rd(ram_rd3), .ram_dout(ram_dout3), .busy(busy3));

  initial for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h5A;

  // RAM models: 1-stage and 3-stage read pipelines
  always @(posedge clk) begin
    ram_dout1 <= mem[ram_addr1];
    r3a       <= mem[ram_addr3];
    r3b       <= r3a;
    ram_dout3 <= r3b;
  end

  // Pulse counters and last RAM address used
  always @(posedge clk) begin
    if (ram_rd1) begin nrd1 <= nrd1 + 1; last_ra1 <= ram_addr1; end
    if (ram_rd3) begin nrd3 <= nrd3 + 1; last_ra3 <= ram_addr3; end
    if (req1) nreq1 <= nreq1 + 1;
    if (req3) nreq3 <= nreq3 + 1;
  end

  function automatic logic [7:0] ref_byte(input logic [24:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return (a < 25'd2048) ? (lo ^ 8'h5A) : 8'hFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [24:0] a);
    ioctl_rd = 1'b1; ioctl_addr = a;
    tick(1);
    ioctl_rd = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pause1"}, 32'(pause1), 0);  check({tag, "_pause3"}, 32'(pause3), 0);
    check({tag, "_busy1"}, 32'(busy1), 0);    check({tag, "_busy3"}, 32'(busy3), 0);
    check({tag, "_rd1"}, 32'(ram_rd1), 0);    check({tag, "_rd3"}, 32'(ram_rd3), 0);
    check({tag, "_req1"}, 32'(req1), 0);      check({tag, "_req3"}, 32'(req3), 0);
    check({tag, "_ra1"}, 32'(ram_addr1), 0);  check({tag, "_ra3"}, 32'(ram_addr3), 0);
    check({tag, "_din1"}, 32'(din1), 0);      check({tag, "_din3"}, 32'(din3), 0);
  endtask

  // One read, spaced like hps_io; checks data, RAM access count and address
  task automatic read_check(input string tag, input logic [24:0] a);
    int r1, r3;
    logic [7:0] e;
    int inr;
    r1 = nrd1; r3 = nrd3; e = ref_byte(a); inr = (a < 25'd2048) ? 1 : 0;
    strobe(a);
    tick(6);
    @(negedge clk);
    check({tag, "_din1"}, 32'(din1), 32'(e));
    check({tag, "_din3"}, 32'(din3), 32'(e));
    check({tag, "_nrd1"}, 32'(nrd1 - r1), 32'(inr));
    check({tag, "_nrd3"}, 32'(nrd3 - r3), 32'(inr));
    if (inr == 1) begin
      check({tag, "_ra1"}, 32'(last_ra1), 32'(a[10:0]));
      check({tag, "_ra3"}, 32'(last_ra3), 32'(a[10:0]));
    end
    exp_din = e;
    tick(1);
  endtask

  // Read with exact latency check: new byte RD_LAT+1 cycles after the strobe
  task automatic timed_read(input string tag, input logic [24:0] a);
    logic [7:0] e;
    e = ref_byte(a);
    strobe(a);
    @(negedge clk); @(negedge clk);
    check({tag, "_early1"}, 32'(din1), 32'(exp_din));
    @(negedge clk);
    check({tag, "_lat1"}, 32'(din1), 32'(e));
    @(negedge clk);
    check({tag, "_early3"}, 32'(din3), 32'(exp_din));
    @(negedge clk);
    check({tag, "_lat3"}, 32'(din3), 32'(e));
    exp_din = e;
    tick(3);
  endtask

  initial begin
    logic [24:0] a, a2;
    int r1, r3, q1, q3, inr;

    reset = 1'b1; save_trig = 1'b0; ioctl_upload = 1'b0; ioctl_rd = 1'b0;
    pause_ack = 1'b0; ioctl_index = IDX_ROM; ioctl_addr = '0; exp_din = 8'h00;
    tick(3);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    tick(2);

    // Save trigger: one pulse, second edge ignored
    q1 = nreq1; q3 = nreq3;
    save_trig = 1'b1; tick(2);
    save_trig = 1'b0; tick(3);
    check("req_pulse1", 32'(nreq1 - q1), 1);
    check("req_pulse3", 32'(nreq3 - q3), 1);
    save_trig = 1'b1; tick(4);
    check("req_second1", 32'(nreq1 - q1), 1);
    check("req_second3", 32'(nreq3 - q3), 1);
    save_trig = 1'b0;

    // Session start and basic reads
    ioctl_index = IDX_NVRAM; ioctl_upload = 1'b1;
    tick(1);
    @(negedge clk);
    check("sess_pause1", 32'(pause1), 1); check("sess_busy1", 32'(busy1), 1);
    check("sess_pause3", 32'(pause3), 1); check("sess_busy3", 32'(busy3), 1);
    tick(2);
    pause_ack = 1'b1;
    tick(2);
    timed_read("rd0", 25'h0);
    timed_read("rd1", 25'h1);
    timed_read("rd7ff", 25'h7FF);

    // Out of range
    read_check("oor800", 25'h800);
    read_check("oor1m", 25'h1000000);

    // Randomized reads
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: a = 25'($urandom_range(0, 2047));
        1: a = 25'($urandom_range(2048, 33554431));
        2: a = ($urandom_range(0, 1) == 1) ? 25'd2047 : 25'd2048;
        default: a = 25'($urandom);
      endcase
      read_check("rand", a);
      tick($urandom_range(0, 4));
    end

    // Back-to-back strobes: second one queued while the first is in flight
    a = 25'($urandom_range(0, 2047)); a2 = 25'($urandom_range(0, 2047));
    r1 = nrd1; r3 = nrd3;
    strobe(a); tick(1); strobe(a2);
    tick(10);
    @(negedge clk);
    check("pend_din1", 32'(din1), 32'(ref_byte(a2)));
    check("pend_din3", 32'(din3), 32'(ref_byte(a2)));
    check("pend_nrd1", 32'(nrd1 - r1), 2);
    check("pend_nrd3", 32'(nrd3 - r3), 2);
    exp_din = ref_byte(a2);

    // Stall: read issued while the game still owns the RAM
    ioctl_upload = 1'b0; pause_ack = 1'b0;
    tick(2);
    @(negedge clk);
    check("end_pause1", 32'(pause1), 0); check("end_busy3", 32'(busy3), 0);
    ioctl_upload = 1'b1;
    tick(2);
    r1 = nrd1; r3 = nrd3;
    strobe(25'h10);
    tick(19);
    check("stall_nrd1", 32'(nrd1 - r1), 0);
    check("stall_nrd3", 32'(nrd3 - r3), 0);
    pause_ack = 1'b1;
    @(negedge clk);
    check("stall_pre_rd1", 32'(ram_rd1), 0);
    @(negedge clk);
    check("stall_rd1", 32'(ram_rd1), 1);
    check("stall_rd3", 32'(ram_rd3), 1);
    tick(6);
    @(negedge clk);
    check("stall_din1", 32'(din1), 32'h4A);
    check("stall_din3", 32'(din3), 32'h4A);
    check("stall_cnt1", 32'(nrd1 - r1), 1);
    check("stall_cnt3", 32'(nrd3 - r3), 1);
    exp_din = 8'h4A;

    // Wrong index: strobes ignored
    ioctl_upload = 1'b0; tick(2);
    ioctl_index = IDX_ROM; ioctl_upload = 1'b1;
    r1 = nrd1; r3 = nrd3;
    for (int i = 0; i < 3; i++) begin
      strobe(25'($urandom_range(0, 2047)));
      tick(7);
      @(negedge clk);
      check("widx_pause1", 32'(pause1), 0);
      check("widx_pause3", 32'(pause3), 0);
    end
    ioctl_index = IDX_DIP;
    strobe(25'h20);
    tick(7);
    @(negedge clk);
    check("widx_nrd1", 32'(nrd1 - r1), 0); check("widx_nrd3", 32'(nrd3 - r3), 0);
    check("widx_din1", 32'(din1), 32'(exp_din)); check("widx_din3", 32'(din3), 32'(exp_din));
    check("widx_busy1", 32'(busy1), 0);

    // Abort: session ends while the RAM read is in flight
    ioctl_index = IDX_NVRAM;
    tick(3);
    read_check("pre_abort", 25'h123);
    strobe(25'h200);
    ioctl_upload = 1'b0;
    @(negedge clk); @(negedge clk);
    check("abort_pause1", 32'(pause1), 0); check("abort_busy1", 32'(busy1), 0);
    check("abort_pause3", 32'(pause3), 0); check("abort_busy3", 32'(busy3), 0);
    tick(6);
    @(negedge clk);
    check("abort_din1", 32'(din1), 32'(exp_din));
    check("abort_din3", 32'(din3), 32'(exp_din));

    // Reset mid-session
    ioctl_upload = 1'b1;
    tick(3);
    inr = 0;
    read_check("pre_reset", 25'h77);
    strobe(25'h300);
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    check_idle_outputs("midreset");
    ioctl_upload = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
    @(negedge clk);
    check("post_reset_busy1", 32'(busy1 | busy3), 32'(inr));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
